// File: rtl/vnw_bias_pkg.sv
// Shared types and helpers for the VNW n-well bias ramp controller.
package vnw_bias_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STEP,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE,
    ST_FAULT
  } vnw_ramp_state_e;

  localparam int VNW_CODE_W      = 6;
  localparam int VNW_STEP        = 2;
  localparam int VNW_SETTLE_CYC  = 64;
  localparam int VNW_TIMEOUT_CYC = 1024;

  // Helper operands are 16 bits wide, so CODE_W must not exceed 16.
  localparam int VNW_FN_W        = 16;

  // Move cur toward tgt by at most step. The 17-bit difference means the
  // comparison can never wrap, and the result never passes tgt.
  function automatic logic [VNW_FN_W-1:0] vnw_step_toward(
    input logic [VNW_FN_W-1:0] cur,
    input logic [VNW_FN_W-1:0] tgt,
    input logic [VNW_FN_W-1:0] step
  );
    logic [VNW_FN_W:0]   diff;
    logic [VNW_FN_W-1:0] res;
    if (tgt >= cur) begin
      diff = {1'b0, tgt} - {1'b0, cur};
      res  = (diff <= {1'b0, step}) ? tgt : cur + step;
    end else begin
      diff = {1'b0, cur} - {1'b0, tgt};
      res  = (diff <= {1'b0, step}) ? tgt : cur - step;
    end
    return res;
  endfunction

endpackage

// File: rtl/vnw_bias_ok_sync.sv
// Two-flop synchronizer for the asynchronous analog bias_ok monitor.
module vnw_bias_ok_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the async monitor; both stages clear on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/vnw_bias_ramp_ctrl.sv
// VNW n-well body-bias ramp controller.
// Accepts a target DAC code, ramps bias_code in bounded steps with a settle
// interval after each update, then waits for the synchronized bias_ok.
// Optional build macro VNW_RAMP_STATUS_EN adds the step_cnt and last_ok_lat
// status outputs.
//
// state     | meaning
// ----------+------------------------------------------------------
// ST_IDLE   | ready for a new target
// ST_STEP   | one-cycle code update toward target
// ST_SETTLE | hold code for SETTLE_CYC cycles
// ST_CHECK  | wait for bok_s, bounded by TIMEOUT_CYC
// ST_DONE   | one-cycle done pulse
// ST_FAULT  | bias_ok timeout, sticky until fault_clr
module vnw_bias_ramp_ctrl
  import vnw_bias_pkg::*;
#(
  parameter int                CODE_W      = VNW_CODE_W,
  parameter int                STEP        = VNW_STEP,
  parameter int                SETTLE_CYC  = VNW_SETTLE_CYC,
  parameter int                TIMEOUT_CYC = VNW_TIMEOUT_CYC,
  parameter logic [CODE_W-1:0] RESET_CODE  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CODE_W-1:0] req_code,
  output logic [CODE_W-1:0] bias_code,
  output logic              bias_en,
  input  logic              bias_ok,
  output logic              busy,
  output logic              done,
  output logic              fault,
`ifdef VNW_RAMP_STATUS_EN
  output logic [7:0]        step_cnt,
  output logic [15:0]       last_ok_lat,
`endif
  input  logic              fault_clr
);

  localparam int CNT_MAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  vnw_ramp_state_e   state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CODE_W-1:0] target_q, target_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CODE_W-1:0] code_step;
  logic              bias_en_q;
  logic              bok_s;

  vnw_bias_ok_sync u_bok_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bias_ok),
    .q     (bok_s)
  );

  assign code_step = CODE_W'(vnw_step_toward(VNW_FN_W'(code_q), VNW_FN_W'(target_q),
                                             VNW_FN_W'(STEP)));

  // State, counter, target and code registers; bias_en tracks the next code.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      target_q  <= RESET_CODE;
      code_q    <= RESET_CODE;
      bias_en_q <= (RESET_CODE != '0);
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      target_q  <= target_d;
      code_q    <= code_d;
      bias_en_q <= (code_d != '0);
    end
  end

  // Next-state, counter and code update for the ramp sequence.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    code_d   = code_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          target_d = req_code;
          cnt_d    = '0;
          state_d  = (req_code == code_q) ? ST_CHECK : ST_STEP;
        end
      end
      ST_STEP: begin
        code_d  = code_step;
        cnt_d   = '0;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = (code_q != target_q) ? ST_STEP : ST_CHECK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CHECK: begin
        if (bok_s) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          cnt_d   = '0;
          state_d = ST_FAULT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_FAULT: if (fault_clr) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign bias_code = code_q;
  assign bias_en   = bias_en_q;
  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_STEP) || (state_q == ST_SETTLE) ||
                     (state_q == ST_CHECK) || (state_q == ST_DONE);
  assign done      = (state_q == ST_DONE);
  assign fault     = (state_q == ST_FAULT);

`ifdef VNW_RAMP_STATUS_EN
  logic [7:0]  step_cnt_q;
  logic [15:0] chk_lat_q;
  logic [15:0] last_ok_lat_q;

  // Ramp step count and CHECK-to-bias_ok latency, both saturating.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_cnt_q    <= '0;
      chk_lat_q     <= '0;
      last_ok_lat_q <= '0;
    end else begin
      if (state_q == ST_IDLE && req_valid)
        step_cnt_q <= '0;
      else if (state_q == ST_STEP && step_cnt_q != 8'hFF)
        step_cnt_q <= step_cnt_q + 8'd1;

      if (state_d == ST_CHECK && state_q != ST_CHECK)
        chk_lat_q <= '0;
      else if (state_q == ST_CHECK && !bok_s && chk_lat_q != 16'hFFFF)
        chk_lat_q <= chk_lat_q + 16'd1;

      if (state_q == ST_CHECK && bok_s)
        last_ok_lat_q <= chk_lat_q;
    end
  end

  assign step_cnt    = step_cnt_q;
  assign last_ok_lat = last_ok_lat_q;
`else
  // Status counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_vnw_bias_ramp_ctrl.sv
// Directed testbench for vnw_bias_ramp_ctrl (STEP=2, SETTLE_CYC=4, TIMEOUT_CYC=8).
module tb_vnw_bias_ramp_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [5:0] req_code;
  logic [5:0] bias_code;
  logic       bias_en;
  logic       bias_ok;
  logic       busy;
  logic       done;
  logic       fault;
  logic       fault_clr;
`ifdef VNW_RAMP_STATUS_EN
  logic [7:0]  step_cnt;
  logic [15:0] last_ok_lat;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [5:0] chg_val [8];
  int         chg_at  [8];
  logic       chg_en  [8];
  int         n_chg, n_done, done_at, fault_at, ready_at;

  always #5 clk = ~clk;

  vnw_bias_ramp_ctrl #(
    .CODE_W      (6),
    .STEP        (2),
    .SETTLE_CYC  (4),
    .TIMEOUT_CYC (8),
    .RESET_CODE  (6'd0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_code    (req_code),
    .bias_code   (bias_code),
    .bias_en     (bias_en),
    .bias_ok     (bias_ok),
    .busy        (busy),
    .done        (done),
    .fault       (fault),
`ifdef VNW_RAMP_STATUS_EN
    .step_cnt    (step_cnt),
    .last_ok_lat (last_ok_lat),
`endif
    .fault_clr   (fault_clr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Follow the DUT until it returns to IDLE or faults, logging code changes.
  task automatic watch(input int budget);
    logic [5:0] prev;
    bit         fin;
    prev = bias_code; fin = 0;
    n_chg = 0; n_done = 0; done_at = -1; fault_at = -1; ready_at = -1;
    for (int k = 1; k <= budget && !fin; k++) begin
      tick();
      if (bias_code !== prev) begin
        if (n_chg < 8) begin
          chg_val[n_chg] = bias_code;
          chg_at[n_chg]  = k;
          chg_en[n_chg]  = bias_en;
        end
        n_chg++;
        prev = bias_code;
      end
      if (done) begin n_done++; done_at = k; end
      if (fault) begin fault_at = k; fin = 1; end
      else if (req_ready) begin ready_at = k; fin = 1; end
    end
    if (!fin) chk("watch_budget", 0, 1);
  endtask

  task automatic do_req(input logic [5:0] code, input bit hold, input logic [5:0] hold_code);
    chk("pre_ready", {31'd0, req_ready}, 1);
    req_valid = 1'b1;
    req_code  = code;
    tick();
    chk("acc_busy", {31'd0, busy}, 1);
    chk("acc_ready", {31'd0, req_ready}, 0);
    if (hold) req_code = hold_code;
    else      req_valid = 1'b0;
    watch(200);
  endtask

  task automatic chk_chg(input string tag, input int i, input logic [5:0] v, input int at);
    chk($sformatf("%s_val%0d", tag, i), {26'd0, chg_val[i]}, {26'd0, v});
    chk($sformatf("%s_at%0d", tag, i), chg_at[i], at);
  endtask

  initial begin
    int nd, nc;
    rst_n = 1'b0; req_valid = 1'b0; req_code = '0; bias_ok = 1'b1; fault_clr = 1'b0;
    tick(); tick();
    chk("rst_code", {26'd0, bias_code}, 0);
    chk("rst_en", {31'd0, bias_en}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_fault", {31'd0, fault}, 0);
    chk("rst_ready", {31'd0, req_ready}, 1);
    rst_n = 1'b1;
    tick(); tick(); tick();

    // Up-ramp 0 -> 5
    do_req(6'd5, 0, 6'd0);
    chk("t1_nchg", n_chg, 3);
    chk_chg("t1", 0, 6'd2, 1);
    chk_chg("t1", 1, 6'd4, 6);
    chk_chg("t1", 2, 6'd5, 11);
    chk("t1_ndone", n_done, 1);
    chk("t1_done_at", done_at, 16);
    chk("t1_ready_at", ready_at, 17);
    chk("t1_fault", {31'd0, fault}, 0);
`ifdef VNW_RAMP_STATUS_EN
    chk("t1_step_cnt", {24'd0, step_cnt}, 3);
    chk("t1_ok_lat", {16'd0, last_ok_lat}, 0);
`endif

    // Down-ramp 5 -> 0
    do_req(6'd0, 0, 6'd0);
    chk("t2_nchg", n_chg, 3);
    chk_chg("t2", 0, 6'd3, 1);
    chk_chg("t2", 1, 6'd1, 6);
    chk_chg("t2", 2, 6'd0, 11);
    chk("t2_en1", {31'd0, chg_en[1]}, 1);
    chk("t2_en_at0", {31'd0, chg_en[2]}, 0);
    chk("t2_done_at", done_at, 16);

    // 0 -> 3, then same-code request 3 -> 3
    do_req(6'd3, 0, 6'd0);
    chk("t3a_nchg", n_chg, 2);
    chk_chg("t3a", 1, 6'd3, 6);
    chk("t3a_done_at", done_at, 11);
    do_req(6'd3, 0, 6'd0);
    chk("t3_nchg", n_chg, 0);
    chk("t3_ndone", n_done, 1);
    chk("t3_done_at", done_at, 1);
    chk("t3_ready_at", ready_at, 2);

    // bias_ok timeout: 3 -> 5 with bias_ok low
    bias_ok = 1'b0;
    tick(); tick(); tick();
    do_req(6'd5, 0, 6'd0);
    chk("t4_nchg", n_chg, 1);
    chk_chg("t4", 0, 6'd5, 1);
    chk("t4_fault_at", fault_at, 13);
    chk("t4_ndone", n_done, 0);
    req_valid = 1'b1; req_code = 6'd1;
    tick(); tick();
    chk("t4_fault_sticky", {31'd0, fault}, 1);
    chk("t4_ready", {31'd0, req_ready}, 0);
    chk("t4_busy", {31'd0, busy}, 0);
    chk("t4_hold", {26'd0, bias_code}, 5);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    bias_ok = 1'b1;
    chk("t4_clr_fault", {31'd0, fault}, 0);
    chk("t4_clr_ready", {31'd0, req_ready}, 1);
    chk("t4_clr_busy", {31'd0, busy}, 0);
    chk("t4_clr_code", {26'd0, bias_code}, 5);
    tick();
    chk("t4_acc_busy", {31'd0, busy}, 1);
    req_valid = 1'b0;
    watch(200);
    chk_chg("t4b", 0, 6'd3, 1);
    chk_chg("t4b", 1, 6'd1, 6);
    chk("t4b_done_at", done_at, 11);

    // Request held during a ramp: 1 -> 6 with a pending 0
    do_req(6'd6, 1, 6'd0);
    chk("t5_nchg", n_chg, 3);
    chk_chg("t5", 2, 6'd6, 11);
    chk("t5_done_at", done_at, 16);
    chk("t5_ready_at", ready_at, 17);
    tick();
    chk("t5_acc_busy", {31'd0, busy}, 1);
    req_valid = 1'b0;
    watch(200);
    chk("t5b_nchg", n_chg, 3);
    chk_chg("t5b", 0, 6'd4, 1);
    chk_chg("t5b", 2, 6'd0, 11);
    chk("t5b_done_at", done_at, 16);

    // Reset during SETTLE at code 4
    req_valid = 1'b1; req_code = 6'd6;
    tick();
    req_valid = 1'b0;
    for (int k = 1; k <= 7; k++) tick();
    chk("t6_pre_code", {26'd0, bias_code}, 4);
    chk("t6_pre_busy", {31'd0, busy}, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_code", {26'd0, bias_code}, 0);
    chk("t6_en", {31'd0, bias_en}, 0);
    chk("t6_busy", {31'd0, busy}, 0);
    chk("t6_done", {31'd0, done}, 0);
    chk("t6_ready", {31'd0, req_ready}, 1);
    nd = 0; nc = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done) nd++;
      if (bias_code !== 6'd0 || !req_ready) nc++;
    end
    chk("t6_no_done", nd, 0);
    chk("t6_idle_hold", nc, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
